// File: rtl/ahb_sram_trafgen.sv
// AHB-lite master traffic generator: writes a pattern over a word window, reads it back,
// compares, and reports pass/fail, error count, first failing address and watchdog timeout.
module ahb_sram_trafgen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       LEN_W     = 16,
    parameter int unsigned       CNT_W     = 8,
    parameter logic [63:0]       SEED      = 64'hA5A5_5A5A,
    parameter int unsigned       TIMEOUT   = 64
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        mode,
    output logic              hsel,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              hready,
    input  logic              hready_resp,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam int unsigned       BYTES    = DATA_W / 8;
    localparam int unsigned       WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BYTES);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] SEED_D   = SEED[DATA_W-1:0];
    localparam logic [DATA_W-1:0] ALT_EVEN = {BYTES{8'h55}};
    localparam logic [DATA_W-1:0] ALT_ODD  = {BYTES{8'hAA}};
    localparam logic [2:0]        HSIZE    = (DATA_W == 64) ? 3'd3 :
                                             (DATA_W == 32) ? 3'd2 :
                                             (DATA_W == 16) ? 3'd1 : 3'd0;
    localparam logic [1:0]        RESP_ERR = 2'b01;

    typedef enum logic [2:0] {StIdle, StWa, StWd, StRa, StRd, StFin} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [ADDR_W-1:0]  fail_q, fail_d;
    logic               tmo_q, tmo_d;
    logic               pass_q, pass_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    logic [DATA_W-1:0]  addr_ext;
    logic [DATA_W-1:0]  patt;
    logic               beat_err;
    logic               last_beat;
    logic               pass_now;

    // Address-based patterns use the low DATA_W bits of the byte address.
    if (DATA_W > ADDR_W) begin : g_addr_zext
        assign addr_ext = {{(DATA_W - ADDR_W){1'b0}}, addr_q};
    end else begin : g_addr_trunc
        assign addr_ext = addr_q[DATA_W-1:0];
    end

    always_comb begin
        patt = addr_ext;
        unique case (mode_q)
            2'd0: patt = addr_ext;
            2'd1: patt = ~addr_ext;
            2'd2: patt = addr_ext ^ SEED_D;
            2'd3: patt = idx_q[0] ? ALT_ODD : ALT_EVEN;
            default: patt = addr_ext;
        endcase
    end

    assign last_beat = (idx_q == len_q - LEN_W'(1));
    assign pass_now  = (err_q == '0) && !tmo_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        pass_d   = pass_q;
        wdog_d   = wdog_q;
        beat_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len;
                    mode_d  = mode;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    err_d   = '0;
                    fail_d  = '0;
                    tmo_d   = 1'b0;
                    pass_d  = 1'b0;
                    state_d = (len != '0) ? StWa : StFin;
                end
            end
            StWa: begin
                wdata_d = patt;
                wdog_d  = '0;
                state_d = StWd;
            end
            StRa: begin
                wdog_d  = '0;
                state_d = StRd;
            end
            StWd, StRd: begin
                if (hready_resp) begin
                    // A read beat with both ERROR and bad data still counts once.
                    beat_err = (hresp == RESP_ERR) || ((state_q == StRd) && (hrdata != patt));
                    if (last_beat) begin
                        idx_d   = '0;
                        addr_d  = BASE_ADDR;
                        state_d = (state_q == StWd) ? StRa : StFin;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        addr_d  = addr_q + STEP;
                        state_d = (state_q == StWd) ? StWa : StRa;
                    end
                end else if (wdog_q == WD_LAST) begin
                    beat_err = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = StFin;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            StFin: begin
                pass_d  = pass_now;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (beat_err) begin
            if (err_q == '0) begin
                fail_d = addr_q;
            end
            if (err_q != '1) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            tmo_q   <= 1'b0;
            pass_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            pass_q  <= pass_d;
            wdog_q  <= wdog_d;
        end
    end

    assign hsel      = (state_q == StWa) || (state_q == StRa);
    assign hwrite    = (state_q == StWa);
    assign htrans    = hsel ? 2'b10 : 2'b00;
    assign hsize     = HSIZE;
    assign haddr     = addr_q;
    assign hwdata    = wdata_q;
    assign hready    = hready_resp;
    assign busy      = (state_q == StWa) || (state_q == StWd) ||
                       (state_q == StRa) || (state_q == StRd);
    assign done      = (state_q == StFin);
    assign pass      = (state_q == StFin) ? pass_now : pass_q;
    assign timeout   = tmo_q;
    assign err_cnt   = err_q;
    assign fail_addr = fail_q;

endmodule

// File: tb/tb_ahb_sram_trafgen.sv
// Directed bench for ahb_sram_trafgen with a small AHB-lite SRAM slave model
// supporting wait states, read corruption, ERROR responses and a stuck-low ready.
module tb_ahb_sram_trafgen;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        start;
    logic [15:0] len;
    logic [1:0]  mode;
    logic        hsel, hwrite, hready, busy, done, pass, timeout;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, fail_addr;
    logic [7:0]  err_cnt;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    ahb_sram_trafgen dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .start       (start),
        .len         (len),
        .mode        (mode),
        .hsel        (hsel),
        .hwrite      (hwrite),
        .htrans      (htrans),
        .hsize       (hsize),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hready      (hready),
        .hready_resp (hready_resp),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .err_cnt     (err_cnt),
        .fail_addr   (fail_addr)
    );

    always #5 hclk = ~hclk;

    // Slave model
    logic [31:0] mem [0:63];
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;
    int          ws_cnt;
    int          wait_cfg;
    logic        hang, corrupt_en, err_en;
    logic [31:0] corrupt_addr, err_addr;

    assign hready_resp = hang ? 1'b0 : (!dp_valid || ws_cnt >= wait_cfg);
    assign hresp       = (dp_valid && err_en && dp_addr == err_addr) ? 2'b01 : 2'b00;
    assign hrdata      = mem[dp_addr[7:2]] ^
                         ((corrupt_en && dp_addr == corrupt_addr) ? 32'h1 : 32'h0);

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            ws_cnt   <= 0;
        end else begin
            if (dp_valid && hready_resp) begin
                dp_valid <= 1'b0;
                if (dp_write) mem[dp_addr[7:2]] <= hwdata;
            end else if (dp_valid) begin
                ws_cnt <= ws_cnt + 1;
            end
            if (hsel && htrans == 2'b10) begin
                dp_valid <= 1'b1;
                dp_write <= hwrite;
                dp_addr  <= haddr;
                ws_cnt   <= 0;
            end
        end
    end

    // Bus monitor
    logic [31:0] addr_log[$];
    logic        wr_log[$];
    int          done_cnt = 0;

    always @(posedge hclk) begin
        if (hsel && htrans == 2'b10) begin
            addr_log.push_back(haddr);
            wr_log.push_back(hwrite);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] l, input logic [1:0] m);
        @(negedge hclk);
        start = 1'b1;
        len   = l;
        mode  = m;
        @(negedge hclk);
        start = 1'b0;
    endtask

    // Counts cycles from the first address phase until done is seen.
    task automatic wait_done(input int cyc0, input int limit, output int cyc);
        cyc = cyc0;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge hclk);
            cyc++;
        end
    endtask

    int cyc;
    int done_base;

    initial begin
        hreset = 1'b1; start = 1'b0; len = '0; mode = '0;
        wait_cfg = 0; hang = 1'b0; corrupt_en = 1'b0; err_en = 1'b0;
        corrupt_addr = '0; err_addr = '0;
        repeat (2) @(negedge hclk);

        check("rst_hsel", hsel, 1'b0);
        check("rst_htrans", htrans, 2'b00);
        check("rst_hwrite", hwrite, 1'b0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h0);
        check("rst_fail_addr", fail_addr, 32'h0);
        check("hsize", hsize, 3'd2);
        hreset = 1'b0;
        @(negedge hclk);

        // len=4 mode 0, zero wait states
        addr_log.delete();
        wr_log.delete();
        pulse_start(16'd4, 2'd0);
        check("t1_wa_hsel", hsel, 1'b1);
        check("t1_wa_htrans", htrans, 2'b10);
        wait_done(0, 100, cyc);
        check("t1_done_cycle", cyc, 16);
        check("t1_pass", pass, 1'b1);
        check("t1_err_cnt", err_cnt, 8'h0);
        check("t1_busy_fin", busy, 1'b0);
        check("t1_beats", addr_log.size(), 8);
        for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
            check($sformatf("t1_haddr%0d", i), addr_log[i], 32'((i % 4) * 4));
            check($sformatf("t1_hwrite%0d", i), wr_log[i], (i < 4) ? 1'b1 : 1'b0);
        end
        @(negedge hclk);
        check("t1_done_pulse", done, 1'b0);
        check("t1_pass_held", pass, 1'b1);

        // len=2 mode 1, three wait states per beat
        wait_cfg = 3;
        pulse_start(16'd2, 2'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check($sformatf("t2_hwdata0_c%0d", i), hwdata, 32'hFFFF_FFFF);
        end
        @(negedge hclk);
        check("t2_haddr1", haddr, 32'h4);
        @(negedge hclk);
        check("t2_hwdata1", hwdata, 32'hFFFF_FFFB);
        wait_done(6, 200, cyc);
        check("t2_done_cycle", cyc, 20);
        check("t2_pass", pass, 1'b1);
        wait_cfg = 0;

        // len=8 mode 2, readback of word 5 corrupted
        corrupt_en = 1'b1;
        corrupt_addr = 32'h14;
        pulse_start(16'd8, 2'd2);
        @(negedge hclk);
        check("t3_hwdata0", hwdata, 32'hA5A5_5A5A);
        repeat (2) @(negedge hclk);
        check("t3_hwdata1", hwdata, 32'hA5A5_5A5E);
        wait_done(3, 200, cyc);
        check("t3_done_cycle", cyc, 32);
        check("t3_err_cnt", err_cnt, 8'h1);
        check("t3_fail_addr", fail_addr, 32'h14);
        check("t3_pass", pass, 1'b0);
        check("t3_timeout", timeout, 1'b0);
        corrupt_en = 1'b0;

        // ready stuck low in the first write data phase
        hang = 1'b1;
        pulse_start(16'd4, 2'd0);
        wait_done(0, 200, cyc);
        check("t4_done_cycle", cyc, 65);
        check("t4_timeout", timeout, 1'b1);
        check("t4_err_cnt", err_cnt, 8'h1);
        check("t4_fail_addr", fail_addr, 32'h0);
        check("t4_pass", pass, 1'b0);
        hang = 1'b0;
        @(negedge hclk);
        check("t4_timeout_sticky", timeout, 1'b1);
        check("t4_done_pulse", done, 1'b0);

        // len=0 run finishes at once and clears prior failure status
        pulse_start(16'd0, 2'd0);
        check("t5_done", done, 1'b1);
        check("t5_pass", pass, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_timeout", timeout, 1'b0);
        check("t5_err_cnt", err_cnt, 8'h0);
        @(negedge hclk);
        check("t5_done_pulse", done, 1'b0);

        // ERROR on write and read of word 2, read also corrupted: one error per beat
        err_en = 1'b1; err_addr = 32'h8;
        corrupt_en = 1'b1; corrupt_addr = 32'h8;
        pulse_start(16'd4, 2'd1);
        wait_done(0, 100, cyc);
        check("t6_done_cycle", cyc, 16);
        check("t6_err_cnt", err_cnt, 8'h2);
        check("t6_fail_addr", fail_addr, 32'h8);
        check("t6_pass", pass, 1'b0);
        err_en = 1'b0;
        corrupt_en = 1'b0;

        // start while busy is ignored; mode 3 alternating pattern
        pulse_start(16'd2, 2'd3);
        @(negedge hclk);
        check("t7_hwdata0", hwdata, 32'h5555_5555);
        start = 1'b1;
        len = 16'd0;
        @(negedge hclk);
        start = 1'b0;
        check("t7_busy", busy, 1'b1);
        @(negedge hclk);
        check("t7_hwdata1", hwdata, 32'hAAAA_AAAA);
        wait_done(3, 100, cyc);
        check("t7_done_cycle", cyc, 8);
        check("t7_pass", pass, 1'b1);
        check("t7_err_cnt", err_cnt, 8'h0);

        // asynchronous reset during the read data phase of word 3
        pulse_start(16'd8, 2'd0);
        repeat (23) @(negedge hclk);
        check("t8_pre_haddr", haddr, 32'hC);
        check("t8_pre_hwdata", hwdata, 32'h1C);
        check("t8_pre_busy", busy, 1'b1);
        done_base = done_cnt;
        #2 hreset = 1'b1;
        #1;
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_haddr", haddr, 32'h0);
        check("t8_rst_hwdata", hwdata, 32'h0);
        check("t8_rst_hsel", hsel, 1'b0);
        check("t8_rst_done", done, 1'b0);
        repeat (3) @(negedge hclk);
        check("t8_no_done", done_cnt, done_base);
        hreset = 1'b0;
        @(negedge hclk);
        pulse_start(16'd4, 2'd2);
        wait_done(0, 100, cyc);
        check("t8_done_cycle", cyc, 16);
        check("t8_pass", pass, 1'b1);
        check("t8_err_cnt", err_cnt, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_trafgen.md
Name: ahb_sram_trafgen

Overview:
Parametrised, synthesizable AHB-lite master traffic generator for the SRAM controller subsystem. It writes a configurable pattern over an address window using single NONSEQ word transfers, reads the window back, compares the data and reports pass/fail, error count and first failing address. It replaces hand-written directed stimulus and can sit in the bench or in silicon beside sramc_top. Over the previous stimulus it adds width/depth generality, pattern modes, wait-state tolerance, HRESP checking and a timeout watchdog.

Parameters:
ADDR_W, 32, haddr width
DATA_W, 32, hwdata/hrdata width; one of 8/16/32/64
BASE_ADDR, 0, byte address of word 0
LEN_W, 16, width of the len input (maximum window is 2^LEN_W-1 words)
CNT_W, 8, width of err_cnt (saturating)
SEED, 32'hA5A5_5A5A, XOR key for mode 2 (truncated or zero-extended to DATA_W)
TIMEOUT, 64, maximum consecutive hready_resp-low cycles in one data phase

Ports:
hclk  in  1  clock
hreset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only when busy=0
len  in  LEN_W  number of words; sampled on start
mode  in  2  pattern: 0 data=addr, 1 data=~addr, 2 data=addr^SEED, 3 data=alternating 0x55../0xAA.. by word index parity; sampled on start
hsel  out  1  slave select
hwrite  out  1  1=write
htrans  out  2  2'b10 NONSEQ or 2'b00 IDLE
hsize  out  3  log2(DATA_W/8), constant
haddr  out  ADDR_W  byte address
hwdata  out  DATA_W  write data
hready  out  1  bus ready to slave, combinational copy of hready_resp
hready_resp  in  1  slave ready
hresp  in  2  slave response; 2'b01 means ERROR
hrdata  in  DATA_W  read data
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  1 when err_cnt=0 and no timeout; valid from done until next start
timeout  out  1  sticky; set when the watchdog fired during the run
err_cnt  out  CNT_W  mismatches plus ERROR responses; saturates at all-ones
fail_addr  out  ADDR_W  address of the first error in the run

Behaviour:
- Reset values: hsel=0, hwrite=0, htrans=IDLE, haddr=0, hwdata=0, busy=0, done=0, pass=0, timeout=0, err_cnt=0, fail_addr=0, FSM in IDLE, idx=0. hreset mid-run aborts immediately; no done pulse is generated.
- FSM states: IDLE, WA, WD, RA, RD, FIN.
- IDLE: start with len!=0 latches len and mode, clears err_cnt, timeout, pass and fail_addr, sets busy=1, idx=0, then goes to WA. start with len=0 goes to FIN with pass=1.
- WA (1 cycle): hsel=1, htrans=NONSEQ, hwrite=1, haddr=BASE_ADDR+idx*(DATA_W/8). Next state is WD.
- WD: htrans=IDLE, hsel=0, hwdata=pattern(idx), held stable until the cycle with hready_resp=1. In that cycle:
  - if hresp=ERROR: err_cnt++ and record fail_addr if this is the first error;
  - idx++; if idx was len-1 go to RA with idx=0, otherwise go to WA.
- RA/RD: same as WA/WD with hwrite=0. In the RD completion cycle: mismatch (hrdata!=pattern(idx)) or ERROR counts one error (never two for the same beat), and the first error records fail_addr. After the last word go to FIN.
- Throughput: 2 cycles per word with zero wait states. A len=N run therefore takes 4N cycles from the WA entry to FIN.
- Watchdog: a counter clears on entry to WD/RD and increments while hready_resp=0. When it reaches TIMEOUT: set timeout, err_cnt++, record fail_addr if first, go to FIN and abandon the remaining beats.
- FIN (1 cycle): done=1, busy=0, pass=(err_cnt==0 && !timeout). Then return to IDLE. Status outputs are held until the next accepted start.
- start while busy is ignored. err_cnt saturates and never wraps. haddr wraps modulo 2^ADDR_W.
- Pattern width rule: pattern(idx) is computed at DATA_W. Address-based patterns use the low DATA_W bits of haddr, zero-extended when DATA_W>ADDR_W.

Test Plan:
- Reset, then start with len=4, mode=0, zero-wait slave with correct memory -> haddr sequence 0,4,8,C for writes then reads; done pulses at cycle 16 after WA entry; pass=1; err_cnt=0.
- len=2, mode=1, slave inserts 3 wait states per beat -> hwdata holds 32'hFFFF_FFFF for 4 cycles; hwdata for the second beat is 32'hFFFF_FFFB; pass=1.
- len=8, slave corrupts the readback of word 5 (haddr=0x14) -> err_cnt=1, fail_addr=0x14, pass=0.
- hready_resp held low in the WD of word 0 with TIMEOUT=64 -> after 64 cycles timeout=1, err_cnt=1, fail_addr=0, done pulses, pass=0.
- start pulsed again while busy, then len=0 -> second start ignored during the run; len=0 run gives done the next cycle with pass=1.
- hreset asserted during RD of word 3 -> all outputs return to reset values asynchronously; no done pulse; a new start runs normally.
